// File: rtl/command_decoder_multi.sv
// UART command decoder: matches a table of mnemonics followed by a terminator, then issues a command and follows the start/finish handshake.
// Optional feature macro CMD_TIMEOUT_EN discards partial commands after IDLE_TIMEOUT quiet cycles.
module command_decoder_multi #(
  parameter int CMD_CHARS = 2,
  parameter int N_CMDS = 4,
  parameter logic [N_CMDS*CMD_CHARS*8-1:0] CMD_TABLE = "rarbwawb",
  parameter logic [7:0] TERMINATOR = 8'h0A,
  parameter int ACK_TIMEOUT = 16,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                byte_received,
  input  logic                      rx_data_ready,
  input  logic                      coprocessor_busy,
  input  logic                      err_clr,
  output logic                      cmd_valid,
  output logic [$clog2(N_CMDS)-1:0] cmd_id,
  output logic [1:0]                state_o,
  output logic                      err_unknown,
  output logic                      err_ack_timeout,
  output logic                      err_overrun
);
  localparam int W = CMD_CHARS * 8;
  localparam int ID_W = $clog2(N_CMDS);
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    BUSY     = 2'd3
  } state_t;

  state_t state, state_next;
  logic [W-1:0] window;
  logic [ACK_W-1:0] ack_cnt;
  logic match_hit;
  logic [ID_W-1:0] match_idx;
  logic strobe_idle, term_idle, ack_expire, idle_expire;

  assign strobe_idle = rx_data_ready && (state == IDLE);
  assign term_idle   = strobe_idle && (byte_received == TERMINATOR);
  assign ack_expire  = (state == WAIT_ACK) && !coprocessor_busy &&
                       (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

  // Descending scan so the lowest matching entry is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = N_CMDS - 1; i >= 0; i--) begin
      if (window == CMD_TABLE[(N_CMDS-1-i)*W +: W]) begin
        match_hit = 1'b1;
        match_idx = ID_W'(i);
      end
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int IT_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IT_W-1:0] idle_cnt;

  assign idle_expire = (state == IDLE) && !rx_data_ready &&
                       (idle_cnt == IT_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state != IDLE) || rx_data_ready || idle_expire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // Without the idle timeout a partial command waits indefinitely.
  logic unused_idle_timeout;
  assign unused_idle_timeout = ^IDLE_TIMEOUT;
  assign idle_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (term_idle && match_hit) state_next = ISSUE;
      ISSUE:    state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (coprocessor_busy) state_next = BUSY;
        else if (ack_expire)  state_next = IDLE;
      end
      BUSY:     if (!coprocessor_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window          <= '0;
      cmd_id          <= '0;
      ack_cnt         <= '0;
      err_unknown     <= 1'b0;
      err_ack_timeout <= 1'b0;
      err_overrun     <= 1'b0;
    end else begin
      err_unknown     <= term_idle && !match_hit;
      err_ack_timeout <= ack_expire;
      // A terminator always empties the window so stale bytes cannot re-match.
      if (term_idle) begin
        window <= '0;
      end else if (strobe_idle) begin
        window <= W'({window, byte_received});
      end else if (idle_expire) begin
        window <= '0;
      end
      if (term_idle && match_hit) begin
        cmd_id <= match_idx;
      end
      if ((state == WAIT_ACK) && !coprocessor_busy && !ack_expire) begin
        ack_cnt <= ack_cnt + 1'b1;
      end else begin
        ack_cnt <= '0;
      end
      if (rx_data_ready && (state != IDLE)) begin
        err_overrun <= 1'b1;
      end else if (err_clr) begin
        err_overrun <= 1'b0;
      end
    end
  end

  assign cmd_valid = (state == ISSUE);
  assign state_o   = state;

endmodule

// File: tb/tb_command_decoder_multi.sv
// Bench for command_decoder_multi: directed steps plus random commands checked against a byte-history model.
module tb_command_decoder_multi;
  localparam int ACK_TIMEOUT = 16;
`ifdef CMD_TIMEOUT_EN
  localparam int IDLE_TIMEOUT = 100;
`else
  localparam int IDLE_TIMEOUT = 1000000;
`endif
  localparam logic [7:0] TERM = 8'h0A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_received = 8'h00;
  logic       rx_data_ready = 1'b0;
  logic       coprocessor_busy = 1'b0;
  logic       err_clr = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [1:0] state_o;
  logic       err_unknown, err_ack_timeout, err_overrun;

  command_decoder_multi #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .byte_received(byte_received),
    .rx_data_ready(rx_data_ready),
    .coprocessor_busy(coprocessor_busy),
    .err_clr(err_clr),
    .cmd_valid(cmd_valid),
    .cmd_id(cmd_id),
    .state_o(state_o),
    .err_unknown(err_unknown),
    .err_ack_timeout(err_ack_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int valid_seen = 0;
  int valid_exp = 0;
  logic [7:0] hist[$];
  string names[4] = '{"ra", "rb", "wa", "wb"};

  always @(negedge clk) if (cmd_valid) valid_seen++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a command is the last two bytes since the previous terminator or reset.
  function automatic int model_lookup();
    int n;
    n = hist.size();
    if (n < 2) return -1;
    for (int i = 0; i < 4; i++) begin
      if (hist[n-2] == names[i][0] && hist[n-1] == names[i][1]) return i;
    end
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) tick;
    if (n > IDLE_TIMEOUT) hist.delete();
  endtask

  task automatic send(input logic [7:0] b, output int res);
    byte_received = b;
    rx_data_ready = 1'b1;
    tick;
    rx_data_ready = 1'b0;
    res = -2;
    if (b != TERM) begin
      hist.push_back(b);
      check("idle_after_byte", state_o, 0);
    end else begin
      res = model_lookup();
      hist.delete();
      if (res >= 0) begin
        valid_exp++;
        check("issue_state", state_o, 1);
        check("cmd_valid_latency", cmd_valid, 1);
        check("cmd_id", cmd_id, res);
      end else begin
        check("err_unknown_set", err_unknown, 1);
        check("no_cmd_valid", cmd_valid, 0);
        check("unknown_state", state_o, 0);
        tick;
        check("err_unknown_pulse", err_unknown, 0);
      end
    end
  endtask

  task automatic cmd2(input logic [7:0] a, input logic [7:0] b, output int res);
    int r;
    send(a, r);
    send(b, r);
    send(TERM, res);
  endtask

  // Called right after ISSUE is observed; busy stays low for d WAIT_ACK cycles.
  task automatic ack_to_busy(input int d, output bit reached);
    coprocessor_busy = 1'b0;
    tick;
    check("wait_ack_state", state_o, 2);
    check("cmd_valid_one_cycle", cmd_valid, 0);
    if (d >= ACK_TIMEOUT) begin
      reached = 1'b0;
      repeat (ACK_TIMEOUT - 1) tick;
      check("still_wait_ack", state_o, 2);
      check("no_early_timeout", err_ack_timeout, 0);
      tick;
      check("timeout_idle", state_o, 0);
      check("err_ack_timeout_set", err_ack_timeout, 1);
      tick;
      check("err_ack_timeout_pulse", err_ack_timeout, 0);
    end else begin
      reached = 1'b1;
      repeat (d) tick;
      coprocessor_busy = 1'b1;
      tick;
      check("busy_state", state_o, 3);
      check("no_timeout_in_busy", err_ack_timeout, 0);
    end
  endtask

  task automatic busy_phase(input int hold, input bit ovr);
    if (ovr) begin
      byte_received = "r";
      rx_data_ready = 1'b1;
      tick;
      rx_data_ready = 1'b0;
      check("overrun_set", err_overrun, 1);
      tick;
      check("overrun_sticky", err_overrun, 1);
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      check("overrun_cleared", err_overrun, 0);
    end
    repeat (hold) tick;
    check("busy_hold", state_o, 3);
    coprocessor_busy = 1'b0;
    tick;
    check("busy_release_idle", state_o, 0);
  endtask

  initial begin
    int res;
    bit reached;
    string alpha;
    alpha = "rwabx";

    // Reset state
    repeat (2) tick;
    check("rst_state", state_o, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_errors", {err_unknown, err_ack_timeout, err_overrun}, 0);
    rst = 1'b1;
    tick;

    // "rb": busy three cycles after cmd_valid, held ten cycles
    cmd2("r", "b", res);
    ack_to_busy(2, reached);
    busy_phase(9, 1'b0);

    // Unknown mnemonic
    cmd2("x", "y", res);

    // Ack timeout, then a normal command
    cmd2("w", "a", res);
    ack_to_busy(ACK_TIMEOUT, reached);
    cmd2("r", "a", res);
    ack_to_busy(0, reached);
    busy_phase(1, 1'b0);

    // Busy on the last allowed WAIT_ACK cycle beats the timeout; overrun with clear in the same cycle
    cmd2("w", "b", res);
    ack_to_busy(ACK_TIMEOUT - 1, reached);
    byte_received = "r";
    rx_data_ready = 1'b1;
    err_clr = 1'b1;
    tick;
    rx_data_ready = 1'b0;
    err_clr = 1'b0;
    check("overrun_set_beats_clear", err_overrun, 1);
    tick;
    check("overrun_sticky_after", err_overrun, 1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("overrun_clear", err_overrun, 0);
    coprocessor_busy = 1'b0;
    tick;
    check("idle_after_busy", state_o, 0);
    // The dropped "r" must not pair with this "b"
    send("b", res);
    send(TERM, res);
    cmd2("w", "b", res);
    ack_to_busy(1, reached);
    busy_phase(2, 1'b1);

    // Asynchronous reset during BUSY
    cmd2("r", "a", res);
    coprocessor_busy = 1'b1;
    tick;
    tick;
    check("busy_before_reset", state_o, 3);
    byte_received = "w";
    rx_data_ready = 1'b1;
    tick;
    rx_data_ready = 1'b0;
    check("overrun_before_reset", err_overrun, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", state_o, 0);
    check("async_rst_outputs", {cmd_valid, err_unknown, err_ack_timeout, err_overrun}, 0);
    check("async_rst_cmd_id", cmd_id, 0);
    coprocessor_busy = 1'b0;
    hist.delete();
    tick;
    rst = 1'b1;
    tick;
    check("post_reset_no_valid", cmd_valid, 0);
    cmd2("r", "a", res);
    ack_to_busy(3, reached);
    busy_phase(2, 1'b0);

    // Long and short gaps inside a partial command
    send("r", res);
    idle(150);
    send("a", res);
    send(TERM, res);
    if (res >= 0) begin
      ack_to_busy(0, reached);
      busy_phase(1, 1'b0);
    end
    send("r", res);
    idle(50);
    send("a", res);
    send(TERM, res);
    ack_to_busy(0, reached);
    busy_phase(1, 1'b0);

    // Random commands with leading garbage, random ack delays and overruns
    for (int it = 0; it < 40; it++) begin
      int len;
      len = $urandom_range(0, 4);
      for (int k = 0; k < len; k++) begin
        send(alpha[$urandom_range(0, 4)], res);
        idle($urandom_range(0, 2));
      end
      send(TERM, res);
      if (res >= 0) begin
        ack_to_busy($urandom_range(0, ACK_TIMEOUT + 2), reached);
        if (reached) busy_phase($urandom_range(1, 5), ($urandom_range(0, 3) == 0));
      end
    end

    tick;
    check("cmd_valid_count", valid_seen, valid_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
